// File: rtl/sa_sum_collector.sv
// Receive side of the serial adder link: shifts in an LSB-first sum frame plus carry-out
// and holds the WIDTH+1-bit result behind a valid/ack handshake. Optional checker: SA_COLLECT_ERR_EN.
module sa_sum_collector #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_vld,
   input  logic             co_in,
   input  logic             done_in,
   output logic [WIDTH:0]   result,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic             last_bit;

   // Edge that accepts the final bit of the frame; start pre-empts it.
   assign last_bit = (state == COLLECT) && !start && bit_vld && (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         shreg        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= '0;
                  count <= '0;
                  state <= COLLECT;
                  busy  <= 1'b1;
               end
            end
            COLLECT: begin
               if (start) begin
                  shreg <= '0;
                  count <= '0;
               end else if (bit_vld) begin
                  shreg <= {bit_in, shreg[WIDTH-1:1]};
                  if (last_bit) begin
                     result       <= {co_in, bit_in, shreg[WIDTH-1:1]};
                     result_valid <= 1'b1;
                     count        <= '0;
                     state        <= HOLD;
                     busy         <= 1'b0;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            HOLD: begin
               // A start without ack is dropped; with ack it opens the next frame directly.
               if (result_ack) begin
                  result_valid <= 1'b0;
                  if (start) begin
                     shreg <= '0;
                     count <= '0;
                     state <= COLLECT;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SA_COLLECT_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else begin
         err <= ((state == IDLE) && bit_vld) ||
                ((state == COLLECT) && start) ||
                ((state == HOLD) && start && !result_ack) ||
                ((state == COLLECT) && done_in && !last_bit);
      end
   end
`else
   logic unused_done;
   assign unused_done = done_in;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sa_sum_collector.sv
// Scoreboard bench for sa_sum_collector (WIDTH=4): expected results are queued as frames
// are driven and compared when result_valid shows up.
module tb_sa_sum_collector;

   localparam int WIDTH = 4;
`ifdef SA_COLLECT_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start, bit_in, bit_vld, co_in, done_in, result_ack;
   logic [WIDTH:0]   result;
   logic             result_valid, busy, err;

   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   exp_r;
   logic [WIDTH:0]   held;
   int               n_cmp = 0;
   int               n_bad = 0;

   always #5 clk = ~clk;

   sa_sum_collector #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_vld(bit_vld),
      .co_in(co_in), .done_in(done_in), .result(result), .result_valid(result_valid),
      .result_ack(result_ack), .busy(busy), .err(err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic co, input logic last);
      bit_vld = 1'b1; bit_in = b; co_in = co; done_in = last;
      step();
      bit_vld = 1'b0; bit_in = 1'b0; co_in = 1'b0; done_in = 1'b0;
   endtask

   // Drives bits LSB first with `gap` idle cycles between bits; queues the expected result.
   task automatic send_frame(input logic [WIDTH-1:0] bits, input logic co, input int gap);
      exp_q.push_back({co, bits});
      for (int i = 0; i < WIDTH; i++) begin
         if (i > 0)
            for (int g = 0; g < gap; g++) step();
         send_bit(bits[i], (i == WIDTH - 1) ? co : 1'b0, i == WIDTH - 1);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      start = 0; bit_in = 0; bit_vld = 0; co_in = 0; done_in = 0; result_ack = 0;
      #12;
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result got %b want %b", result, 5'b0); end
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", result_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic;
      pulse_start();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
      send_frame(4'b1111, 1'b0, 0);
      exp_r = exp_q.pop_front();
      n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", result_valid); end
      n_cmp++; if (result !== exp_r) begin n_bad++; $display("FAIL basic_result got %b want %b", result, exp_r); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_hold got %b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", err); end
      result_ack = 1'b1; step(); result_ack = 1'b0;
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack_valid got %b want 0", result_valid); end
      n_cmp++; if (result !== exp_r) begin n_bad++; $display("FAIL basic_keep got %b want %b", result, exp_r); end
   endtask

   task automatic test_ack;
      pulse_start();
      send_frame(4'b0010, 1'b1, 0);
      exp_r = exp_q.pop_front();
      n_cmp++; if (result !== exp_r || result_valid !== 1'b1) begin n_bad++; $display("FAIL ack_result got %b/%b want %b/1", result, result_valid, exp_r); end
      result_ack = 1'b1; step();
      n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL ack_valid got %b want 0", result_valid); end
      // Ack held on into IDLE must do nothing.
      step(); result_ack = 1'b0;
      n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin n_bad++; $display("FAIL ack_idle got v=%b b=%b r=%b want 0/0/%b", result_valid, busy, result, exp_r); end
   endtask

   task automatic test_gaps;
      pulse_start();
      send_frame(4'b1110, 1'b1, 2);
      exp_r = exp_q.pop_front();
      n_cmp++; if (result !== exp_r || result_valid !== 1'b1) begin n_bad++; $display("FAIL gaps_result got %b/%b want %b/1", result, result_valid, exp_r); end
      held = exp_r;
   endtask

   task automatic test_hold;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if (result !== held || result_valid !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL hold_stable got %b/%b/%b want %b/1/0", result, result_valid, err, held); end
      end
      pulse_start();
      n_cmp++; if (result !== held || result_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_drop got %b/%b/%b want %b/1/0", result, result_valid, busy, held); end
      n_cmp++; if (err !== ERR_EN) begin n_bad++; $display("FAIL hold_err got %b want %b", err, ERR_EN); end
      step();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hold_err_clear got %b want 0", err); end
      start = 1'b1; result_ack = 1'b1; step(); start = 1'b0; result_ack = 1'b0;
      n_cmp++; if (busy !== 1'b1 || result_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_state got busy=%b v=%b want 1/0", busy, result_valid); end
      send_frame(4'b1001, 1'b0, 1);
      exp_r = exp_q.pop_front();
      n_cmp++; if (result !== exp_r || result_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_result got %b/%b want %b/1", result, result_valid, exp_r); end
      result_ack = 1'b1; step(); result_ack = 1'b0;
   endtask

   task automatic test_restart;
      logic [WIDTH-1:0] bits;
      bits = 4'b0101;
      pulse_start();
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      pulse_start();
      n_cmp++; if (err !== ERR_EN || busy !== 1'b1) begin n_bad++; $display("FAIL restart_err got err=%b busy=%b want %b/1", err, busy, ERR_EN); end
      exp_q.push_back({1'b0, bits});
      for (int i = 0; i < WIDTH; i++) begin
         send_bit(bits[i], 1'b0, i == WIDTH - 1);
         n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL restart_err_once bit %0d got %b want 0", i, err); end
      end
      exp_r = exp_q.pop_front();
      n_cmp++; if (result !== exp_r || result_valid !== 1'b1) begin n_bad++; $display("FAIL restart_result got %b/%b want %b/1", result, result_valid, exp_r); end
      result_ack = 1'b1; step(); result_ack = 1'b0;
   endtask

   task automatic test_reset_mid;
      pulse_start();
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midreset got r=%b v=%b b=%b e=%b want all 0", result, result_valid, busy, err); end
      #3 rst = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0);
      n_cmp++; if (err !== ERR_EN) begin n_bad++; $display("FAIL idle_bit_err got %b want %b", err, ERR_EN); end
      send_bit(1'b1, 1'b1, 1'b1);
      step(); step();
      n_cmp++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL post_reset got v=%b b=%b want 0/0", result_valid, busy); end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_ack();
      test_gaps();
      test_hold();
      test_restart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
